// File: rtl/rand_src.sv
// rand_src -- bounded pseudo-random number source.
//
// A free-running value counter (cnt) cycles 0..MAX_VAL. By default it is
// advanced by a prescaler tick every DIV clocks. The counter is sampled onto
// num in one of two ways:
//   track mode    (mode=0): num follows cnt on every cycle that run_in is high.
//   one-shot mode (mode=1): a rising edge of run_in captures one value, pulses
//                           valid, and holds busy until run_in returns low.
//                           Two consecutive one-shot results are never equal.
//
// Optional build macro: RAND_SRC_LFSR_EN
//   When defined, a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1)
//   advances cnt on every cycle where lfsr[0]=1, and the prescaler tick is
//   no longer used by cnt.
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   asynchronous active-high reset
//   mode    in   0 = track, 1 = one-shot
//   run_in  in   capture request (level in track, edge in one-shot)
//   num     out  [W-1:0] captured value (registered)
//   valid   out  one-cycle pulse for each new one-shot result
//   busy    out  high while a one-shot capture waits for run_in to drop
module rand_src #(
  parameter int W       = 4,
  parameter int MAX_VAL = 9,
  parameter int DIV     = 5_000_000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         mode,
  input  logic         run_in,
  output logic [W-1:0] num,
  output logic         valid,
  output logic         busy
);

  localparam logic [W-1:0] MAX_W    = W'(MAX_VAL);
  localparam logic [25:0]  DIV_LAST = 26'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [25:0]  div_cnt_q, div_cnt_d;
  logic         tick;
  logic         adv;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] num_q, num_d;
  logic [W-1:0] last_q, last_d;
  logic [W-1:0] sample;
  logic         valid_q, valid_d;
  logic         has_prev_q, has_prev_d;
  logic         run_prev_q;

  // Increment with wrap from MAX_VAL back to 0.
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] v);
    return (v == MAX_W) ? '0 : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------- prescaler
  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + 26'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // ------------------------------------------------------- counter advance
`ifdef RAND_SRC_LFSR_EN
  logic [15:0] lfsr_q;

  // Right-shifting Galois form; taps 16,14,13,11 give the mask 16'hB400.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign adv = lfsr_q[0];
`else
  assign adv = tick;
`endif

  // cnt runs freely regardless of mode, run_in or FSM state.
  assign cnt_d = adv ? wrap_inc(cnt_q) : cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------- capture FSM
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    last_d     = last_q;
    has_prev_d = has_prev_q;
    valid_d    = 1'b0;
    // Avoid repeating the previous one-shot result. cnt_q is the pre-tick
    // value, so a coincident tick does not affect what is captured.
    sample     = (has_prev_q && (cnt_q == last_q)) ? wrap_inc(cnt_q) : cnt_q;

    case (state_q)
      IDLE: begin
        if (!mode && run_in) begin
          state_d = TRACK;
          num_d   = cnt_q;
        end else if (mode && run_in && !run_prev_q) begin
          state_d    = WAIT_LOW;
          num_d      = sample;
          last_d     = sample;
          has_prev_d = 1'b1;
          valid_d    = 1'b1;
        end
      end
      TRACK: begin
        if (!run_in || mode) begin
          state_d = IDLE;
        end else begin
          num_d = cnt_q;
        end
      end
      WAIT_LOW: begin
        // mode is deliberately ignored here; it is re-evaluated in IDLE.
        if (!run_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      num_q      <= '0;
      last_q     <= '0;
      has_prev_q <= 1'b0;
      valid_q    <= 1'b0;
      run_prev_q <= 1'b0;  // a level held high across reset counts as an edge
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      last_q     <= last_d;
      has_prev_q <= has_prev_d;
      valid_q    <= valid_d;
      run_prev_q <= run_in;
    end
  end

  assign num   = num_q;
  assign valid = valid_q;
  assign busy  = (state_q == WAIT_LOW);

endmodule

// File: tb/tb_rand_src.sv
// Scoreboard bench for rand_src (W=4, MAX_VAL=9, DIV=4). The driver updates
// an abstract behavioural model on each clock edge and queues the expected
// outputs; a monitor on the falling edge pops and compares them.
module tb_rand_src;

  localparam int W       = 4;
  localparam int MAX_VAL = 9;
  localparam int DIV     = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         mode = 1'b0;
  logic         run_in = 1'b0;
  logic [W-1:0] num;
  logic         valid;
  logic         busy;

  always #5 CLK = ~CLK;

  rand_src #(.W(W), .MAX_VAL(MAX_VAL), .DIV(DIV)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .mode  (mode),
    .run_in(run_in),
    .num   (num),
    .valid (valid),
    .busy  (busy)
  );

  typedef struct {
    int num;
    bit valid;
    bit busy;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   shot_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state.
  int m_edges;   // clock edges since reset release
  int m_cnt;     // counter value after the latest edge
  bit m_prev;    // run_in at the previous edge
  bit m_wait;    // one-shot result delivered, waiting for run_in low
  bit m_has;
  int m_last;
  int m_num;
  int m_lfsr;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_cnt   = 0;
    m_prev  = 0;
    m_wait  = 0;
    m_has   = 0;
    m_last  = 0;
    m_num   = 0;
    m_lfsr  = 'hACE1;
  endtask

  task automatic model_edge(input bit m, input bit r);
    int   pre;
    int   s;
    bit   v;
    exp_t e;
    pre = m_cnt;
    v   = 0;
    if (m_wait) begin
      if (!r) m_wait = 0;
    end else if (!m) begin
      if (r) m_num = pre;
    end else if (r && !m_prev) begin
      s      = (m_has && pre == m_last) ? (pre + 1) % (MAX_VAL + 1) : pre;
      m_num  = s;
      m_last = s;
      m_has  = 1;
      m_wait = 1;
      v      = 1;
      shot_q.push_back(s);
    end
    m_prev = r;
    m_edges++;
`ifdef RAND_SRC_LFSR_EN
    if ((m_lfsr & 1) != 0) m_cnt = (m_cnt + 1) % (MAX_VAL + 1);
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
`else
    m_cnt = (m_edges / DIV) % (MAX_VAL + 1);
`endif
    e.num   = m_num;
    e.valid = v;
    e.busy  = m_wait;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit m, input bit r);
    mode   = m;
    run_in = r;
    @(posedge CLK);
    model_edge(m, r);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    #1 RST = 1'b1;
    model_reset();
    repeat (n) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Wait (run_in low) until the counter holds v, then issue one capture.
  task automatic shot_at(input int v, input int hold);
    int n;
    n = 0;
    while (m_cnt != v && n < 200) begin
      step(1, 0);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL shot_wait actual=timeout expected=cnt_%0d", v);
    end
    step(1, 1);
    repeat (hold) step(1, 1);
    step(1, 0);
    step(1, 0);
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      check("reset_num", int'(num), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_busy", int'(busy), 0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("num", int'(num), e.num);
        check("valid", int'(valid), int'(e.valid));
        check("busy", int'(busy), int'(e.busy));
        check("cnt", int'(dut.cnt_q), e.cnt);
      end
      if (valid) begin
        if (shot_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL shot_unexpected actual=valid num=%0d expected=no_valid", num);
        end else begin
          check("shot_num", int'(num), shot_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit r;
    bit m;
    model_reset();
    do_reset(2);

    // Idle run: counter wraps, num stays 0.
    repeat (40) step(0, 0);
`ifndef RAND_SRC_LFSR_EN
    check("cnt_after_40", int'(dut.cnt_q), 0);
`endif
    check("num_idle", int'(num), 0);

    // Track window on clocks 10..21.
    do_reset(2);
    repeat (9) step(0, 0);
    repeat (12) step(0, 1);
    repeat (5) step(0, 0);
`ifndef RAND_SRC_LFSR_EN
    check("track_hold", int'(num), 5);
`endif

    // One-shot captures, no-repeat rule and wrap.
    do_reset(2);
    shot_at(6, 20);
    shot_at(6, 3);
    shot_at(9, 3);
    shot_at(9, 3);
`ifndef RAND_SRC_LFSR_EN
    check("wrap_num", int'(num), 0);
`endif

    // Reset while busy clears has_prev.
    shot_at(6, 0);
    while (m_cnt != 6) step(1, 0);
    step(1, 1);
    step(1, 1);
    step(1, 1);
    run_in = 1'b0;
    do_reset(2);
    shot_at(6, 2);

    // run_in held high across reset release in one-shot mode.
    mode   = 1'b1;
    run_in = 1'b1;
    do_reset(2);
    repeat (3) step(1, 1);
    step(1, 0);

    // Randomized traffic.
    m = 0;
    r = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) m = ~m;
      if ($urandom_range(0, 3) == 0) r = ~r;
      if ($urandom_range(0, 299) == 0) begin
        mode   = m;
        run_in = r;
        do_reset($urandom_range(1, 3));
      end
      step(m, r);
    end

    @(negedge CLK);
    #1;
    check("shots_pending", shot_q.size(), 0);
    check("exp_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
